// File: rtl/pad_attr_pkg.sv
// Shared types for the pad-attribute configuration path: FSM state enum and
// register-layer request/response structs at the default attribute width.
package pad_attr_pkg;

  localparam int unsigned ATTR_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_RESP
  } pad_attr_state_e;

  typedef struct packed {
    logic               write;
    logic [ATTR_DW-1:0] wdata;
  } pad_attr_req_t;

  typedef struct packed {
    logic [ATTR_DW-1:0] rdata;
    logic               err;
  } pad_attr_rsp_t;

endpackage

// File: rtl/pad_attr_settle_timer.sv
// Settle-time counter: loads SettleCycles-1, decrements on request, flags zero.
module pad_attr_settle_timer #(
  parameter int unsigned SettleCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int unsigned CntW = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'((SettleCycles > 0) ? SettleCycles - 1 : 0);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LoadVal;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pad_attr_cfg_ctrl.sv
// Pad attribute config controller: masked per-pad attribute writes with settle
// delay before response. Optional per-pad write lock under `PAD_ATTR_LOCK_EN.
module pad_attr_cfg_ctrl
  import pad_attr_pkg::*;
#(
  parameter  int unsigned NumPads      = 4,
  parameter  int unsigned AttrDw       = 8,
  parameter  int unsigned SettleCycles = 4,
  localparam int unsigned PadIdxW      = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [PadIdxW-1:0]        req_pad_i,
  input  logic [AttrDw-1:0]         req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [AttrDw-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  input  logic [AttrDw-1:0]         attr_supported_i,
  output logic [NumPads*AttrDw-1:0] pad_attr_o,
  output logic                      busy_o
`ifdef PAD_ATTR_LOCK_EN
  ,
  input  logic                      req_lock_i
`endif
);

  pad_attr_state_e     state_q, state_d;
  logic [PadIdxW-1:0]  pad_q;
  logic [AttrDw-1:0]   wdata_q;
  logic [AttrDw-1:0]   attr_q [NumPads];
  logic [AttrDw-1:0]   rdata_q;
  logic                err_q;
  logic                in_range;
  logic                pad_locked;
  logic                write_ok;
  logic                settle_done;

  assign in_range = (32'(req_pad_i) < NumPads);

`ifdef PAD_ATTR_LOCK_EN
  logic               lock_req_q;
  logic [NumPads-1:0] lock_q;
  assign pad_locked = in_range && lock_q[req_pad_i];
`else
  assign pad_locked = 1'b0;
`endif

  assign write_ok = req_write_i && in_range && !pad_locked;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req_valid_i) state_d = write_ok ? ST_APPLY : ST_RESP;
      ST_APPLY:  state_d = (SettleCycles == 0) ? ST_RESP : ST_SETTLE;
      ST_SETTLE: if (settle_done) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // Reads, range errors and lock rejects resolve at accept; good writes resolve in APPLY.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned n = 0; n < NumPads; n++) attr_q[n] <= '0;
      pad_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef PAD_ATTR_LOCK_EN
      lock_req_q <= 1'b0;
      lock_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            pad_q   <= req_pad_i;
            wdata_q <= req_wdata_i;
            err_q   <= !in_range || (req_write_i && pad_locked);
`ifdef PAD_ATTR_LOCK_EN
            lock_req_q <= req_lock_i;
`endif
            if (!in_range)                       rdata_q <= '0;
            else if (!req_write_i || pad_locked) rdata_q <= attr_q[req_pad_i];
          end
        end
        ST_APPLY: begin
          attr_q[pad_q] <= wdata_q & attr_supported_i;
          rdata_q       <= wdata_q & attr_supported_i;
          err_q         <= 1'b0;
`ifdef PAD_ATTR_LOCK_EN
          if (lock_req_q) lock_q[pad_q] <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pad_attr_o = '0;
    for (int unsigned n = 0; n < NumPads; n++) pad_attr_o[n*AttrDw +: AttrDw] = attr_q[n];
  end

  pad_attr_settle_timer #(
    .SettleCycles(SettleCycles)
  ) u_settle (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (state_q == ST_APPLY),
    .dec_i  (state_q == ST_SETTLE),
    .done_o (settle_done)
  );

endmodule

// File: tb/tb_pad_attr_cfg_ctrl.sv
// Bench for pad_attr_cfg_ctrl: 4-pad/settle-4 main instance plus a 3-pad/settle-0
// instance for range-error and zero-settle behaviour, checked against an array model.
module tb_pad_attr_cfg_ctrl;

  localparam int unsigned SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid3, req_write, rsp_ready, rsp_ready3;
  logic [1:0]  req_pad;
  logic [7:0]  req_wdata, supported;
  logic        req_lock;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [7:0]  rsp_rdata;
  logic [31:0] pad_attr;
  logic        req_ready3, rsp_valid3, rsp_err3, busy3;
  logic [7:0]  rsp_rdata3;
  logic [23:0] pad_attr3;

  logic [7:0]  m_attr [4];
  logic [7:0]  m3 [3];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  pad_attr_cfg_ctrl #(.NumPads(4), .AttrDw(8), .SettleCycles(SETTLE)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_pad_i(req_pad), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .attr_supported_i(supported), .pad_attr_o(pad_attr),
    .busy_o(busy)
`ifdef PAD_ATTR_LOCK_EN
    , .req_lock_i(req_lock)
`endif
  );

  pad_attr_cfg_ctrl #(.NumPads(3), .AttrDw(8), .SettleCycles(0)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid3), .req_ready_o(req_ready3),
    .req_write_i(req_write), .req_pad_i(req_pad), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_rdata_o(rsp_rdata3),
    .rsp_err_o(rsp_err3), .attr_supported_i(supported), .pad_attr_o(pad_attr3),
    .busy_o(busy3)
`ifdef PAD_ATTR_LOCK_EN
    , .req_lock_i(1'b0)
`endif
  );

  function automatic logic [31:0] exp_bus();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = m_attr[i];
    return v;
  endfunction

  function automatic logic [23:0] exp_bus3();
    logic [23:0] v;
    for (int i = 0; i < 3; i++) v[i*8 +: 8] = m3[i];
    return v;
  endfunction

  // Issue one request on instance sel, measure edges to response, hold ready off for hold cycles.
  task automatic xact(input int sel, input logic wr, input logic [1:0] pad, input logic [7:0] wd,
                      input int hold, output int lat, output logic [7:0] rd, output logic er);
    @(negedge clk);
    req_write = wr; req_pad = pad; req_wdata = wd;
    if (sel == 0) req_valid = 1'b1; else req_valid3 = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_valid3 = 1'b0;
    lat = 1;
    while (!((sel == 0) ? rsp_valid : rsp_valid3) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = (sel == 0) ? rsp_rdata : rsp_rdata3;
    er = (sel == 0) ? rsp_err : rsp_err3;
    repeat (hold) @(negedge clk);
    if (sel == 0) rsp_ready = 1'b1; else rsp_ready3 = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; rsp_ready3 = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [7:0] rd; logic er;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_err, rsp_rdata, busy, req_ready} !== 12'h001)
      $display("FAIL reset_outputs got %h want 001", {rsp_valid, rsp_err, rsp_rdata, busy, req_ready}); else n_pass++;
    n_checks++; if (pad_attr !== 32'h0 || pad_attr3 !== 24'h0)
      $display("FAIL reset_pad_attr got %h/%h want 0", pad_attr, pad_attr3); else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_attr[i] = 8'h00;
    for (int i = 0; i < 3; i++) m3[i] = 8'h00;
    for (int p = 0; p < 4; p++) begin
      xact(0, 1'b0, 2'(p), 8'h00, 0, lat, rd, er);
      n_checks++; if (lat !== 1 || rd !== 8'h00 || er !== 1'b0)
        $display("FAIL reset_read pad%0d got lat=%0d rd=%h er=%b want lat=1 rd=00 er=0", p, lat, rd, er); else n_pass++;
    end
  endtask

  task automatic test_masked_write();
    int lat; logic [7:0] rd; logic er;
    supported = 8'h0F;
    xact(0, 1'b1, 2'd2, 8'hA5, 0, lat, rd, er);
    m_attr[2] = 8'hA5 & 8'h0F;
    n_checks++; if (lat !== int'(2 + SETTLE))
      $display("FAIL masked_write_latency got %0d want %0d", lat, 2 + SETTLE); else n_pass++;
    n_checks++; if (rd !== 8'h05 || er !== 1'b0)
      $display("FAIL masked_write_rsp got rd=%h er=%b want rd=05 er=0", rd, er); else n_pass++;
    n_checks++; if (pad_attr !== exp_bus())
      $display("FAIL masked_write_bus got %h want %h", pad_attr, exp_bus()); else n_pass++;
  endtask

  task automatic test_no_retro_mask();
    int lat; logic [7:0] rd; logic er;
    supported = 8'hFF;
    xact(0, 1'b1, 2'd0, 8'hC3, 0, lat, rd, er);
    m_attr[0] = 8'hC3;
    supported = 8'h00;
    xact(0, 1'b0, 2'd0, 8'h00, 1, lat, rd, er);
    n_checks++; if (rd !== m_attr[0] || er !== 1'b0 || lat !== 1)
      $display("FAIL no_retro_read got rd=%h er=%b lat=%0d want rd=%h er=0 lat=1", rd, er, lat, m_attr[0]); else n_pass++;
    n_checks++; if (pad_attr !== exp_bus())
      $display("FAIL no_retro_bus got %h want %h", pad_attr, exp_bus()); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] wd;
    int lat;
    wd = 8'($urandom);
    supported = 8'hFF;
    @(negedge clk);
    req_write = 1'b1; req_pad = 2'd1; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    m_attr[1] = wd;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    n_checks++; if (lat !== int'(2 + SETTLE))
      $display("FAIL bp_latency got %0d want %0d", lat, 2 + SETTLE); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== wd || req_ready !== 1'b0)
        $display("FAIL bp_hold cyc%0d got v=%b rd=%h rdy=%b want v=1 rd=%h rdy=0", c, rsp_valid, rsp_rdata, req_ready, wd); else n_pass++;
    end
    rsp_ready = 1'b1;
    req_write = 1'b0; req_pad = 2'd1; req_valid = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL bp_post_handshake got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0", rsp_valid, req_ready, busy); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== wd || rsp_err !== 1'b0)
      $display("FAIL bp_next_read got v=%b rd=%h er=%b want v=1 rd=%h er=0", rsp_valid, rsp_rdata, rsp_err, wd); else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_settle();
    logic seen;
    supported = 8'hFF;
    @(negedge clk);
    req_write = 1'b1; req_pad = 2'd3; req_wdata = 8'h77; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || pad_attr[31:24] !== 8'h77)
      $display("FAIL settle_pre_reset got busy=%b pad3=%h want busy=1 pad3=77", busy, pad_attr[31:24]); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_attr[i] = 8'h00;
    for (int i = 0; i < 3; i++) m3[i] = 8'h00;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || pad_attr !== 32'h0)
      $display("FAIL settle_reset got busy=%b v=%b bus=%h want 0/0/0", busy, rsp_valid, pad_attr); else n_pass++;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen = seen | rsp_valid; end
    n_checks++; if (seen !== 1'b0)
      $display("FAIL settle_reset_no_rsp got rsp_valid seen=%b want 0", seen); else n_pass++;
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [7:0] rd, exp_rd; logic er;
    logic wr; logic [1:0] pad; logic [7:0] wd;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      pad = 2'($urandom_range(0, 3));
      wd = 8'($urandom);
      supported = 8'($urandom);
      xact(0, wr, pad, wd, int'($urandom_range(0, 3)), lat, rd, er);
      if (wr) begin
        m_attr[pad] = wd & supported;
        exp_lat = 2 + SETTLE;
      end else begin
        exp_lat = 1;
      end
      exp_rd = m_attr[pad];
      n_checks++; if (lat !== exp_lat || rd !== exp_rd || er !== 1'b0)
        $display("FAIL rand%0d wr=%b pad%0d got lat=%0d rd=%h er=%b want lat=%0d rd=%h er=0", t, wr, pad, lat, rd, er, exp_lat, exp_rd); else n_pass++;
      n_checks++; if (pad_attr !== exp_bus())
        $display("FAIL rand%0d_bus got %h want %h", t, pad_attr, exp_bus()); else n_pass++;
    end
  endtask

  task automatic test_small_no_settle();
    int lat; logic [7:0] rd; logic er;
    supported = 8'hFF;
    xact(1, 1'b1, 2'd1, 8'h3C, 0, lat, rd, er);
    m3[1] = 8'h3C;
    n_checks++; if (lat !== 2 || rd !== 8'h3C || er !== 1'b0)
      $display("FAIL s0_write got lat=%0d rd=%h er=%b want lat=2 rd=3c er=0", lat, rd, er); else n_pass++;
    n_checks++; if (pad_attr3 !== exp_bus3())
      $display("FAIL s0_bus got %h want %h", pad_attr3, exp_bus3()); else n_pass++;
    xact(1, 1'b1, 2'd3, 8'h55, 0, lat, rd, er);
    n_checks++; if (lat !== 1 || rd !== 8'h00 || er !== 1'b1)
      $display("FAIL oor_write got lat=%0d rd=%h er=%b want lat=1 rd=00 er=1", lat, rd, er); else n_pass++;
    n_checks++; if (pad_attr3 !== exp_bus3())
      $display("FAIL oor_bus got %h want %h", pad_attr3, exp_bus3()); else n_pass++;
    xact(1, 1'b0, 2'd3, 8'h00, 0, lat, rd, er);
    n_checks++; if (lat !== 1 || rd !== 8'h00 || er !== 1'b1)
      $display("FAIL oor_read got lat=%0d rd=%h er=%b want lat=1 rd=00 er=1", lat, rd, er); else n_pass++;
    xact(1, 1'b0, 2'd2, 8'h00, 0, lat, rd, er);
    n_checks++; if (lat !== 1 || rd !== m3[2] || er !== 1'b0)
      $display("FAIL s0_edge_read got lat=%0d rd=%h er=%b want lat=1 rd=%h er=0", lat, rd, er, m3[2]); else n_pass++;
  endtask

`ifdef PAD_ATTR_LOCK_EN
  task automatic test_lock();
    int lat; logic [7:0] rd; logic er;
    supported = 8'hFF;
    req_lock = 1'b1;
    xact(0, 1'b1, 2'd0, 8'h11, 0, lat, rd, er);
    req_lock = 1'b0;
    m_attr[0] = 8'h11;
    n_checks++; if (rd !== 8'h11 || er !== 1'b0)
      $display("FAIL lock_set got rd=%h er=%b want rd=11 er=0", rd, er); else n_pass++;
    xact(0, 1'b1, 2'd0, 8'h22, 0, lat, rd, er);
    n_checks++; if (lat !== 1 || rd !== 8'h11 || er !== 1'b1)
      $display("FAIL lock_reject got lat=%0d rd=%h er=%b want lat=1 rd=11 er=1", lat, rd, er); else n_pass++;
    n_checks++; if (pad_attr !== exp_bus())
      $display("FAIL lock_bus got %h want %h", pad_attr, exp_bus()); else n_pass++;
    xact(0, 1'b0, 2'd0, 8'h00, 0, lat, rd, er);
    n_checks++; if (rd !== 8'h11 || er !== 1'b0)
      $display("FAIL lock_read got rd=%h er=%b want rd=11 er=0", rd, er); else n_pass++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_valid3 = 1'b0; req_write = 1'b0; req_pad = 2'd0;
    req_wdata = 8'h00; rsp_ready = 1'b0; rsp_ready3 = 1'b0; supported = 8'hFF;
    req_lock = 1'b0;
    test_reset();
    test_masked_write();
    test_no_retro_mask();
    test_backpressure();
    test_reset_mid_settle();
    test_random();
    test_small_no_settle();
`ifdef PAD_ATTR_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
